// File: rtl/fft_pkg.sv
// Shared FFT definitions: twiddle scale, sequencer states and
// the N / LOG2N consistency check.
package fft_pkg;

  localparam int TW_ONE = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tw_state_e;

  function automatic bit log2n_ok(input int n, input int l);
    return (l >= 3) && (l <= 12) && (n == (1 << l));
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle ROM: W_N^k for k = 0..N/2-1, Q1.12, built at elaboration.
// Registered read with enable, one cycle latency.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int word_length_tw = 14,
  parameter int N              = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [$clog2(N)-2:0]      addr,
  output logic [word_length_tw-1:0] cos_data,
  output logic [word_length_tw-1:0] sin_data
);

  localparam int  D  = N / 2;
  localparam real PI = 3.14159265358979323846;

  logic [word_length_tw-1:0] cos_tab [D];
  logic [word_length_tw-1:0] sin_tab [D];
  logic [word_length_tw-1:0] cos_q;
  logic [word_length_tw-1:0] sin_q;

  for (genvar i = 0; i < D; i++) begin : g_tab
    localparam real ANG = 2.0 * PI * real'(i) / real'(N);
    localparam real CR  = real'(TW_ONE) * $cos(ANG);
    localparam real SR  = -real'(TW_ONE) * $sin(ANG);
    localparam real CF  = (CR >= 0.0) ? $floor(CR + 0.5)
                                      : -$floor(0.5 - CR);
    localparam real SF  = (SR >= 0.0) ? $floor(SR + 0.5)
                                      : -$floor(0.5 - SR);
    localparam int  CQ  = $rtoi(CF);
    localparam int  SQ  = $rtoi(SF);
    localparam int  CS  = (CQ > TW_ONE)  ? TW_ONE  :
                          (CQ < -TW_ONE) ? -TW_ONE : CQ;
    localparam int  SS  = (SQ > TW_ONE)  ? TW_ONE  :
                          (SQ < -TW_ONE) ? -TW_ONE : SQ;
    assign cos_tab[i] = word_length_tw'(CS);
    assign sin_tab[i] = word_length_tw'(SS);
  end

  // Read port; holds its word whenever en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (en) begin
      cos_q <= cos_tab[addr];
      sin_q <= sin_tab[addr];
    end
  end

  assign cos_data = cos_q;
  assign sin_data = sin_q;

endmodule

// File: rtl/twiddle_sequencer.sv
// Twiddle sequencer: walks butterflies and stages of a radix-2 DIF
// frame and streams W_N^k over a stallable valid/ready port.
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int word_length_tw = 14,
  parameter int N              = 256,
  parameter int LOG2N          = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       tw_ready,
  output logic                       tw_valid,
  output logic [word_length_tw-1:0]  cos_data,
  output logic [word_length_tw-1:0]  sin_data,
  output logic [LOG2N-2:0]           tw_idx,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       last_in_stage,
  output logic                       last_in_frame,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int BW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  if (!log2n_ok(N, LOG2N)) begin : g_bad_log2n
    $error("twiddle_sequencer: LOG2N must equal log2(N), N in 8..4096");
  end

  tw_state_e state_q, state_d;

  logic [BW-1:0] ib_q, ib_d;
  logic [SW-1:0] is_q, is_d;
  logic          idone_q, idone_d;
  logic [BW-1:0] ob_q, ob_d;
  logic [SW-1:0] os_q, os_d;

  logic                      r_vld_q;
  logic [BW-1:0]             r_k_q;
  logic                      o_vld_q;
  logic [BW-1:0]             o_k_q;
  logic [word_length_tw-1:0] o_cos_q;
  logic [word_length_tw-1:0] o_sin_q;

  logic [word_length_tw-1:0] rom_cos;
  logic [word_length_tw-1:0] rom_sin;
  logic [BW-1:0]             k_a;
  logic                      a_vld;
  logic                      adv;
  logic                      issue;
  logic                      xfer;
  logic                      last_xfer;
  logic                      flush;

  // Pipe only moves when the output slot is free or being taken
  assign adv   = !(o_vld_q && !tw_ready);
  assign a_vld = (state_q == RUN) && !idone_q;
  assign issue = adv && a_vld;
  assign xfer  = o_vld_q && tw_ready;
  assign flush = abort || (state_q != RUN);

  assign last_xfer = xfer && (ob_q == B_LAST) && (os_q == S_LAST);

  // k = (b mod (N >> (s+1))) << s, the modulus being a power of two
  assign k_a = BW'((ib_q & (B_LAST >> is_q)) << is_q);

  twiddle_rom #(
    .word_length_tw (word_length_tw),
    .N              (N)
  ) u_rom (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (issue),
    .addr     (k_a),
    .cos_data (rom_cos),
    .sin_data (rom_sin)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; abort overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_xfer) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
  end

  // Issue-side butterfly/stage counters feeding the ROM address
  always_comb begin
    ib_d    = ib_q;
    is_d    = is_q;
    idone_d = idone_q;
    if (flush) begin
      ib_d    = '0;
      is_d    = '0;
      idone_d = 1'b0;
    end else if (issue) begin
      ib_d = ib_q + 1'b1;
      if (ib_q == B_LAST) begin
        if (is_q == S_LAST) begin
          is_d    = '0;
          idone_d = 1'b1;
        end else begin
          is_d = is_q + 1'b1;
        end
      end
    end
  end

  // Output-side counters advance on each accepted twiddle
  always_comb begin
    ob_d = ob_q;
    os_d = os_q;
    if (flush) begin
      ob_d = '0;
      os_d = '0;
    end else if (xfer) begin
      ob_d = ob_q + 1'b1;
      if (ob_q == B_LAST) begin
        os_d = (os_q == S_LAST) ? '0 : os_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ib_q    <= '0;
      is_q    <= '0;
      idone_q <= 1'b0;
      ob_q    <= '0;
      os_q    <= '0;
    end else begin
      ib_q    <= ib_d;
      is_q    <= is_d;
      idone_q <= idone_d;
      ob_q    <= ob_d;
      os_q    <= os_d;
    end
  end

  // ROM-stage tag and output register; frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_q <= 1'b0;
      r_k_q   <= '0;
      o_vld_q <= 1'b0;
      o_k_q   <= '0;
      o_cos_q <= '0;
      o_sin_q <= '0;
    end else if (flush) begin
      r_vld_q <= 1'b0;
      r_k_q   <= '0;
      o_vld_q <= 1'b0;
      o_k_q   <= '0;
      o_cos_q <= '0;
      o_sin_q <= '0;
    end else if (adv) begin
      r_vld_q <= a_vld;
      r_k_q   <= k_a;
      o_vld_q <= r_vld_q;
      o_k_q   <= r_k_q;
      o_cos_q <= rom_cos;
      o_sin_q <= rom_sin;
    end
  end

  assign tw_valid      = o_vld_q;
  assign cos_data      = o_cos_q;
  assign sin_data      = o_sin_q;
  assign tw_idx        = o_k_q;
  assign stage         = os_q;
  assign last_in_stage = o_vld_q && (ob_q == B_LAST);
  assign last_in_frame = last_in_stage && (os_q == S_LAST);

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Scoreboard bench for twiddle_sequencer at N=8, Q1.12 14-bit twiddles.
// Stimulus pushes expected frames; a negedge monitor checks transfers.
module tb_twiddle_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        tw_ready;
  logic        tw_valid;
  logic [13:0] cos_data;
  logic [13:0] sin_data;
  logic [1:0]  tw_idx;
  logic [1:0]  stage;
  logic        last_in_stage;
  logic        last_in_frame;
  logic        busy;
  logic        frame_done;

  twiddle_sequencer #(
    .word_length_tw (14),
    .N              (8),
    .LOG2N          (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .tw_ready      (tw_ready),
    .tw_valid      (tw_valid),
    .cos_data      (cos_data),
    .sin_data      (sin_data),
    .tw_idx        (tw_idx),
    .stage         (stage),
    .last_in_stage (last_in_stage),
    .last_in_frame (last_in_frame),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int k;
    int c;
    int s;
    int st;
    int lis;
    int lif;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_err;
  int   xfer_cnt;

  int kseq [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  int ctab [4]  = '{4096, 2896, 0, -2896};
  int stab [4]  = '{0, -2896, -4096, -2896};

  task automatic check(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int t = 0; t < 12; t++) begin
      e.k   = kseq[t];
      e.c   = ctab[e.k];
      e.s   = stab[e.k];
      e.st  = t / 4;
      e.lis = (t % 4 == 3) ? 1 : 0;
      e.lif = (t == 11) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops on every handshake, checks stall stability and frame_done
  initial begin
    bit          stall_prev;
    bit          expect_done;
    logic [27:0] snap_dat;
    logic [6:0]  snap_ctl;
    exp_t        e;
    stall_prev  = 1'b0;
    expect_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev  = 1'b0;
        expect_done = 1'b0;
        continue;
      end
      if (expect_done) begin
        check("frame_done_pulse", int'(frame_done), 1);
        expect_done = 1'b0;
      end else if (frame_done) begin
        check("frame_done_spurious", int'(frame_done), 0);
      end
      if (stall_prev) begin
        check("stall_data", int'({cos_data, sin_data}), int'(snap_dat));
        check("stall_ctl",
              int'({tw_valid, tw_idx, stage, last_in_stage, last_in_frame}),
              int'(snap_ctl));
      end
      stall_prev = tw_valid && !tw_ready && !abort;
      snap_dat   = {cos_data, sin_data};
      snap_ctl   = {tw_valid, tw_idx, stage, last_in_stage, last_in_frame};
      if (tw_valid && tw_ready && !abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", int'(tw_idx), -1);
        end else begin
          e = exp_q.pop_front();
          check("k", int'(tw_idx), e.k);
          check("cos", int'($signed(cos_data)), e.c);
          check("sin", int'($signed(sin_data)), e.s);
          check("stage", int'(stage), e.st);
          check("last_in_stage", int'(last_in_stage), e.lis);
          check("last_in_frame", int'(last_in_frame), e.lif);
        end
        xfer_cnt++;
        if (last_in_frame) expect_done = 1'b1;
      end
    end
  end

  task automatic start_frame(input bit push);
    @(posedge clk); #1;
    start = 1'b1;
    if (push) push_frame();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Run until the frame drains, optionally re-pulsing start or aborting
  task automatic drain(input bit rnd, input int restart_at,
                       input int abort_at, input int base);
    bit restarted;
    bit done;
    restarted = 1'b0;
    done      = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      tw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!restarted && restart_at >= 0 && xfer_cnt - base == restart_at) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      if (abort_at >= 0 && xfer_cnt - base == abort_at) begin
        abort    = 1'b1;
        tw_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_valid", int'(tw_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(frame_done), 0);
        done = 1'b1;
        break;
      end
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", exp_q.size(), 0);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int base;
    n_chk    = 0;
    n_err    = 0;
    xfer_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(tw_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_idx", int'(tw_idx), 0);
    check("rst_cos", int'(cos_data), 0);
    check("rst_stage", int'(stage), 0);
    rst_n = 1'b1;

    // Latency and full frame with tw_ready held high
    tw_ready = 1'b1;
    base = xfer_cnt;
    start_frame(1'b1);
    @(negedge clk);
    check("lat_busy_e1", int'(busy), 1);
    check("lat_valid_e1", int'(tw_valid), 0);
    @(negedge clk);
    check("lat_valid_e2", int'(tw_valid), 0);
    @(negedge clk);
    check("lat_valid_e3", int'(tw_valid), 1);
    drain(1'b0, -1, -1, base);
    check("frame1_count", xfer_cnt - base, 12);

    // Random back-pressure
    base = xfer_cnt;
    start_frame(1'b1);
    drain(1'b1, -1, -1, base);
    check("frame2_count", xfer_cnt - base, 12);

    // start while busy is ignored
    base = xfer_cnt;
    start_frame(1'b1);
    drain(1'b1, 4, -1, base);
    check("frame3_count", xfer_cnt - base, 12);

    // abort mid-frame, then a clean restart
    base = xfer_cnt;
    start_frame(1'b1);
    drain(1'b1, -1, 5, base);
    check("abort_count", xfer_cnt - base, 5);
    repeat (2) @(negedge clk);
    check("abort_quiet_done", int'(frame_done), 0);
    base = xfer_cnt;
    tw_ready = 1'b1;
    start_frame(1'b1);
    drain(1'b0, -1, -1, base);
    check("frame4_count", xfer_cnt - base, 12);

    // Async reset while stalled, then a clean frame
    base = xfer_cnt;
    tw_ready = 1'b1;
    start_frame(1'b1);
    for (int n = 0; n < 50; n++) begin
      if (xfer_cnt - base >= 3) break;
      @(posedge clk); #1;
    end
    tw_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", int'(tw_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(tw_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_idx", int'(tw_idx), 0);
    check("mid_rst_stage", int'(stage), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tw_ready = 1'b1;
    base = xfer_cnt;
    start_frame(1'b1);
    drain(1'b0, -1, -1, base);
    check("frame5_count", xfer_cnt - base, 12);

    // start together with abort in IDLE stays IDLE
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("sa_valid", int'(tw_valid), 0);
    check("sa_busy_late", int'(busy), 0);
    check("leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
